// File: rtl/unified_mem.sv
// unified_mem: word-organised unified instruction/data memory with a registered read pipeline,
// a side loader port, sticky error capture and saturating access counters.
module unified_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 2,
  parameter logic [31:0] BAD_DATA    = 32'h0000_0000,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   mem_addr,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   mem_write_data,
  output logic [31:0]   mem_read_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          err,
  output logic [31:0]   err_addr,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);
  logic [31:0]   mem [DEPTH_WORDS];
  logic          good, launch, cpu_wr, bad;
  logic [AW-1:0] idx;
  logic          s1_v, s1_good;
  logic [AW-1:0] s1_idx;
  logic          comp_v, comp_good;
  logic [AW-1:0] comp_idx;
  always_comb begin
    good      = mem_addr[1:0] == 2'b00 && mem_addr[31:AW+2] == '0;
    idx       = mem_addr[AW+1:2];
    launch    = reset_n && mem_read;
    cpu_wr    = reset_n && mem_write && good && !ld_en;
    bad       = reset_n && (mem_read || mem_write) && !good;
    comp_v    = (READ_LAT == 1) ? launch : s1_v;
    comp_idx  = (READ_LAT == 1) ? idx    : s1_idx;
    comp_good = (READ_LAT == 1) ? good   : s1_good;
  end
  // Array is never reset; the loader works even while reset_n is low and wins over the CPU.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (cpu_wr) mem[idx] <= mem_write_data;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      s1_v          <= 1'b0;
      s1_good       <= 1'b0;
      s1_idx        <= '0;
      err           <= 1'b0;
      err_addr      <= '0;
      rd_count      <= '0;
      wr_count      <= '0;
    end else begin
      s1_v    <= mem_read;
      s1_good <= good;
      s1_idx  <= idx;
      if (comp_v) mem_read_data <= comp_good ? mem[comp_idx] : BAD_DATA;
      if (comp_v && !(&rd_count)) rd_count <= rd_count + 16'd1;
      if (cpu_wr && !(&wr_count)) wr_count <= wr_count + 16'd1;
      if (bad && !err) begin
        err      <= 1'b1;
        err_addr <= mem_addr;
      end
    end
  end
endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: directed checks of unified_mem with READ_LAT=2 and READ_LAT=1 instances
// driven from the same stimulus.
module tb_unified_mem;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        reset_n, mem_read, mem_write, ld_en;
  logic [31:0] mem_addr, mem_write_data, ld_data;
  logic [9:0]  ld_addr;
  logic [31:0] rd2, rd1, ea2, ea1;
  logic        err2, err1;
  logic [15:0] rc2, rc1, wc2, wc1;
  int          nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  unified_mem #(.DEPTH_WORDS(1024), .READ_LAT(2), .BAD_DATA(BAD)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_write_data(mem_write_data), .mem_read_data(rd2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err2), .err_addr(ea2),
    .rd_count(rc2), .wr_count(wc2));

  unified_mem #(.DEPTH_WORDS(1024), .READ_LAT(1), .BAD_DATA(BAD)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_write_data(mem_write_data), .mem_read_data(rd1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err1), .err_addr(ea1),
    .rd_count(rc1), .wr_count(wc1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
    ld_en = 1'b1; ld_addr = 10'd0; ld_data = 32'h2008_0005;
    tick();
    ld_addr = 10'd1; ld_data = 32'hAC08_0010;
    tick();
    ld_en = 1'b0;
    nchk++; if (rd2 !== 32'h0) begin nfail++; $display("FAIL reset_rd2 got %h want %h", rd2, 32'h0); end
    nchk++; if (rd1 !== 32'h0) begin nfail++; $display("FAIL reset_rd1 got %h want %h", rd1, 32'h0); end
    nchk++; if (err2 !== 1'b0 || ea2 !== 32'h0) begin nfail++; $display("FAIL reset_err got %b/%h want 0/0", err2, ea2); end
    nchk++; if (rc2 !== 16'd0 || wc2 !== 16'd0 || rc1 !== 16'd0 || wc1 !== 16'd0) begin
      nfail++; $display("FAIL reset_counts got %0d %0d %0d %0d want 0 0 0 0", rc2, wc2, rc1, wc1); end
  endtask

  task automatic test_fetch();
    reset_n = 1'b1; mem_read = 1'b1; mem_addr = 32'h0;
    tick();
    nchk++; if (rd1 !== 32'h2008_0005) begin nfail++; $display("FAIL fetch_rd1_e1 got %h want %h", rd1, 32'h2008_0005); end
    nchk++; if (rd2 !== 32'h0) begin nfail++; $display("FAIL fetch_rd2_e1 got %h want %h", rd2, 32'h0); end
    tick();
    mem_read = 1'b0;
    nchk++; if (rd2 !== 32'h2008_0005) begin nfail++; $display("FAIL fetch_rd2_e2 got %h want %h", rd2, 32'h2008_0005); end
    nchk++; if (rc1 !== 16'd2 || rc2 !== 16'd1) begin nfail++; $display("FAIL fetch_rc_e2 got %0d/%0d want 2/1", rc1, rc2); end
    tick();
    nchk++; if (rc2 !== 16'd2) begin nfail++; $display("FAIL fetch_rc2_e3 got %0d want 2", rc2); end
  endtask

  task automatic test_write();
    mem_write = 1'b1; mem_addr = 32'h40; mem_write_data = 32'hCAFE_F00D;
    tick();
    mem_write = 1'b0; mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    tick();
    nchk++; if (rd2 !== 32'hCAFE_F00D || rd1 !== 32'hCAFE_F00D) begin
      nfail++; $display("FAIL write_readback got %h/%h want %h", rd2, rd1, 32'hCAFE_F00D); end
    nchk++; if (wc2 !== 16'd1 || wc1 !== 16'd1) begin nfail++; $display("FAIL write_wc got %0d/%0d want 1", wc2, wc1); end
    nchk++; if (rc2 !== 16'd3 || rc1 !== 16'd3) begin nfail++; $display("FAIL write_rc got %0d/%0d want 3", rc2, rc1); end
  endtask

  task automatic test_rw_same();
    mem_write = 1'b1; mem_addr = 32'h80; mem_write_data = 32'h0;
    tick();
    mem_read = 1'b1; mem_write_data = 32'h1234_5678;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    nchk++; if (rd1 !== 32'h0) begin nfail++; $display("FAIL rw_same_lat1 got %h want %h", rd1, 32'h0); end
    tick();
    nchk++; if (rd2 !== 32'h1234_5678) begin nfail++; $display("FAIL rw_same_lat2 got %h want %h", rd2, 32'h1234_5678); end
    nchk++; if (wc2 !== 16'd3 || rc2 !== 16'd4) begin nfail++; $display("FAIL rw_same_counts got %0d/%0d want 3/4", wc2, rc2); end
  endtask

  task automatic test_error();
    mem_read = 1'b1; mem_addr = 32'h42;
    tick();
    mem_read = 1'b0;
    tick();
    nchk++; if (rd2 !== BAD || rd1 !== BAD) begin nfail++; $display("FAIL err_bad_data got %h/%h want %h", rd2, rd1, BAD); end
    nchk++; if (err2 !== 1'b1 || ea2 !== 32'h42 || err1 !== 1'b1 || ea1 !== 32'h42) begin
      nfail++; $display("FAIL err_capture got %b/%h want 1/%h", err2, ea2, 32'h42); end
    mem_write = 1'b1; mem_addr = 32'h1000; mem_write_data = 32'h5555_5555;
    tick();
    mem_write = 1'b0;
    nchk++; if (wc2 !== 16'd3 || wc1 !== 16'd3) begin nfail++; $display("FAIL err_wc got %0d/%0d want 3", wc2, wc1); end
    nchk++; if (ea2 !== 32'h42) begin nfail++; $display("FAIL err_sticky_addr got %h want %h", ea2, 32'h42); end
    mem_read = 1'b1; mem_addr = 32'h0;
    tick();
    mem_read = 1'b0;
    tick();
    nchk++; if (rd2 !== 32'h2008_0005 || rd1 !== 32'h2008_0005) begin
      nfail++; $display("FAIL err_array_kept got %h/%h want %h", rd2, rd1, 32'h2008_0005); end
    nchk++; if (rc2 !== 16'd6) begin nfail++; $display("FAIL err_rc got %0d want 6", rc2); end
  endtask

  task automatic test_loader();
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hA5A5_0001;
    mem_write = 1'b1; mem_addr = 32'h14; mem_write_data = 32'hBAD0_0000;
    tick();
    ld_en = 1'b0; mem_write = 1'b0; mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    tick();
    nchk++; if (rd2 !== 32'hA5A5_0001 || rd1 !== 32'hA5A5_0001) begin
      nfail++; $display("FAIL loader_priority got %h/%h want %h", rd2, rd1, 32'hA5A5_0001); end
    nchk++; if (wc2 !== 16'd3 || wc1 !== 16'd3) begin nfail++; $display("FAIL loader_wc got %0d/%0d want 3", wc2, wc1); end
  endtask

  task automatic test_back_to_back();
    mem_read = 1'b1; mem_addr = 32'h0;
    tick();
    mem_addr = 32'h4;
    tick();
    mem_read = 1'b0;
    nchk++; if (rd2 !== 32'h2008_0005) begin nfail++; $display("FAIL b2b_rd2_first got %h want %h", rd2, 32'h2008_0005); end
    nchk++; if (rd1 !== 32'hAC08_0010) begin nfail++; $display("FAIL b2b_rd1_second got %h want %h", rd1, 32'hAC08_0010); end
    tick();
    nchk++; if (rd2 !== 32'hAC08_0010) begin nfail++; $display("FAIL b2b_rd2_second got %h want %h", rd2, 32'hAC08_0010); end
    nchk++; if (rc2 !== 16'd9 || rc1 !== 16'd9) begin nfail++; $display("FAIL b2b_rc got %0d/%0d want 9", rc2, rc1); end
  endtask

  task automatic test_reset_in_flight();
    mem_read = 1'b1; mem_addr = 32'h40;
    tick();
    mem_read = 1'b0; reset_n = 1'b0;
    tick();
    nchk++; if (rd2 !== 32'h0 || rc2 !== 16'd0) begin nfail++; $display("FAIL flight_reset got %h/%0d want 0/0", rd2, rc2); end
    nchk++; if (err2 !== 1'b0 || ea2 !== 32'h0) begin nfail++; $display("FAIL flight_err_clr got %b/%h want 0/0", err2, ea2); end
    reset_n = 1'b1;
    tick();
    tick();
    nchk++; if (rd2 !== 32'h0 || rc2 !== 16'd0) begin nfail++; $display("FAIL flight_no_complete got %h/%0d want 0/0", rd2, rc2); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_rw_same();
    test_error();
    test_loader();
    test_back_to_back();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
